// File: rtl/abc_sample_framer.sv
// rtl/abc_sample_framer.sv - three-phase ADC sample to IEEE-754 single frame assembler
module abc_sample_framer #(
    parameter int WIDTH     = 16,
    parameter int SCALE_EXP = -15,
    parameter int MIN_GAP   = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_user,
    input  logic             adc_valid,
    input  logic [1:0]       adc_ch,
    input  logic [WIDTH-1:0] adc_data,
    output logic [31:0]      Va,
    output logic [31:0]      Vb,
    output logic [31:0]      Vc,
    output logic             sta,
    output logic             overrun,
    output logic             dup_err,
    output logic [15:0]      frame_cnt
);
    localparam int           EXP_BASE   = 127 + SCALE_EXP;
    localparam int           GW         = $clog2(MIN_GAP);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(MIN_GAP - 1);

    typedef enum logic {COLLECT, READY} state_t;

    state_t          state_q, state_d;
    logic            s1_valid_q, s1_valid_d;
    logic            s1_sign_q, s1_sign_d;
    logic [WIDTH:0]  s1_mag_q, s1_mag_d;
    logic [1:0]      s1_ch_q, s1_ch_d;
    logic [31:0]     sh_a_q, sh_a_d, sh_b_q, sh_b_d, sh_c_q, sh_c_d;
    logic [31:0]     va_q, va_d, vb_q, vb_d, vc_q, vc_d;
    logic            sta_q, sta_d, overrun_q, overrun_d, dup_q, dup_d;
    logic [15:0]     frame_q, frame_d;
    logic [2:0]      mask_q, mask_d;
    logic [GW-1:0]   gap_q, gap_d;

    logic [WIDTH:0]  sx;
    logic [4:0]      lead;
    int              exp_i;
    logic [22:0]     mant;
    logic [31:0]     flt;
    logic            commit, store;
    logic [2:0]      onehot, mask_base;

    assign sx = {adc_data[WIDTH-1], adc_data};

    // S2 datapath: the magnitude is one bit wider than the sample, so -2^(WIDTH-1) is exact
    always_comb begin
        lead = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            if (s1_mag_q[i]) lead = 5'(i);
        end
        exp_i = EXP_BASE + int'(lead);
        mant  = 23'((48'(s1_mag_q) << (6'd47 - 6'(lead))) >> 24);
        if (s1_mag_q == '0)    flt = '0;
        else if (exp_i <= 0)   flt = {s1_sign_q, 31'b0};
        else if (exp_i >= 255) flt = {s1_sign_q, 8'hFF, 23'b0};
        else                   flt = {s1_sign_q, 8'(exp_i), mant};
    end

    always_comb begin
        s1_valid_d = adc_valid && (adc_ch != 2'd3);
        s1_sign_d  = adc_data[WIDTH-1];
        s1_mag_d   = s1_sign_d ? -sx : sx;
        s1_ch_d    = adc_ch;

        commit    = (state_q == READY) && (gap_q == '0);
        store     = s1_valid_q;
        onehot    = 3'b001 << s1_ch_q;
        mask_base = commit ? 3'b000 : mask_q;
        mask_d    = store ? (mask_base | onehot) : mask_base;

        overrun_d = overrun_q | (store && (mask_q == 3'b111) && !commit);
        dup_d     = dup_q | (store && (mask_q != 3'b111) && ((mask_q & onehot) != 3'b000));

        sh_a_d = (store && s1_ch_q == 2'd0) ? flt : sh_a_q;
        sh_b_d = (store && s1_ch_q == 2'd1) ? flt : sh_b_q;
        sh_c_d = (store && s1_ch_q == 2'd2) ? flt : sh_c_q;

        // Commit publishes the shadows as they stood before any same-edge store
        va_d    = commit ? sh_a_q : va_q;
        vb_d    = commit ? sh_b_q : vb_q;
        vc_d    = commit ? sh_c_q : vc_q;
        sta_d   = commit;
        frame_d = commit ? frame_q + 16'd1 : frame_q;
        gap_d   = commit ? GAP_RELOAD : ((gap_q != '0) ? gap_q - GW'(1) : gap_q);
        state_d = (mask_d == 3'b111) ? READY : COLLECT;

        if (rst_user) begin
            s1_valid_d = 1'b0;
            s1_sign_d  = 1'b0;
            s1_mag_d   = '0;
            s1_ch_d    = '0;
            sh_a_d     = '0;
            sh_b_d     = '0;
            sh_c_d     = '0;
            va_d       = '0;
            vb_d       = '0;
            vc_d       = '0;
            sta_d      = 1'b0;
            overrun_d  = 1'b0;
            dup_d      = 1'b0;
            frame_d    = '0;
            mask_d     = '0;
            gap_d      = '0;
            state_d    = COLLECT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= COLLECT;
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= '0;
            s1_ch_q    <= '0;
            sh_a_q     <= '0;
            sh_b_q     <= '0;
            sh_c_q     <= '0;
            va_q       <= '0;
            vb_q       <= '0;
            vc_q       <= '0;
            sta_q      <= 1'b0;
            overrun_q  <= 1'b0;
            dup_q      <= 1'b0;
            frame_q    <= '0;
            mask_q     <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
            s1_ch_q    <= s1_ch_d;
            sh_a_q     <= sh_a_d;
            sh_b_q     <= sh_b_d;
            sh_c_q     <= sh_c_d;
            va_q       <= va_d;
            vb_q       <= vb_d;
            vc_q       <= vc_d;
            sta_q      <= sta_d;
            overrun_q  <= overrun_d;
            dup_q      <= dup_d;
            frame_q    <= frame_d;
            mask_q     <= mask_d;
            gap_q      <= gap_d;
        end
    end

    assign Va        = va_q;
    assign Vb        = vb_q;
    assign Vc        = vc_q;
    assign sta       = sta_q;
    assign overrun   = overrun_q;
    assign dup_err   = dup_q;
    assign frame_cnt = frame_q;
endmodule

// File: tb/tb_abc_sample_framer.sv
// tb/tb_abc_sample_framer.sv - scoreboard bench for abc_sample_framer
module tb_abc_sample_framer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst_user = 1'b0;
    logic        adc_valid = 1'b0;
    logic [1:0]  adc_ch = 2'd0;
    logic [15:0] adc_data = 16'd0;
    logic [31:0] Va, Vb, Vc;
    logic        sta, overrun, dup_err;
    logic [15:0] frame_cnt;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } frame_t;

    frame_t sb[$];
    int n_vec = 0;
    int n_err = 0;
    int sta_seen = 0;
    int tick = 0;
    int cyc, t0, exp_sta;

    abc_sample_framer #(.WIDTH(16), .SCALE_EXP(-15), .MIN_GAP(128)) dut (
        .clk(clk), .rst(rst), .rst_user(rst_user),
        .adc_valid(adc_valid), .adc_ch(adc_ch), .adc_data(adc_data),
        .Va(Va), .Vb(Vb), .Vc(Vc), .sta(sta), .overrun(overrun),
        .dup_err(dup_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tick++;
    always @(negedge clk) if (sta === 1'b1) sta_seen++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] ch, input logic [15:0] d);
        adc_valid = 1'b1;
        adc_ch    = ch;
        adc_data  = d;
        step();
        adc_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        frame_t f;
        f.a = a;
        f.b = b;
        f.c = c;
        sb.push_back(f);
    endtask

    task automatic wait_sta(input string tag, input int budget, output int n);
        frame_t e;
        n = 0;
        do begin
            step();
            n++;
        end while (sta !== 1'b1 && n < budget);
        chk({tag, "_sta"}, 32'(sta), 32'd1);
        if (sta === 1'b1) begin
            chk({tag, "_sb_has_entry"}, 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({tag, "_Va"}, Va, e.a);
                chk({tag, "_Vb"}, Vb, e.b);
                chk({tag, "_Vc"}, Vc, e.c);
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_Va"}, Va, 32'd0);
        chk({tag, "_Vb"}, Vb, 32'd0);
        chk({tag, "_Vc"}, Vc, 32'd0);
        chk({tag, "_sta"}, 32'(sta), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
        chk({tag, "_dup_err"}, 32'(dup_err), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        chk_zero("reset");
        rst = 1'b1;
        step();

        // single frame
        send(2'd0, 16'h4000);
        send(2'd1, 16'h8000);
        push(32'h3F000000, 32'hBF800000, 32'h00000000);
        send(2'd2, 16'h0000);
        wait_sta("single", 10, cyc);
        chk("single_latency", 32'(cyc), 32'd2);
        chk("single_frame_cnt", 32'(frame_cnt), 32'd1);
        step();
        chk("sta_one_cycle", 32'(sta), 32'd0);

        // conversion corners
        idle(130);
        send(2'd0, 16'h7FFF);
        send(2'd1, 16'h0001);
        push(32'h3F7FFE00, 32'h38000000, 32'hB8000000);
        send(2'd2, 16'hFFFF);
        wait_sta("corner", 10, cyc);
        chk("corner_latency", 32'(cyc), 32'd2);
        chk("corner_frame_cnt", 32'(frame_cnt), 32'd2);

        // channel 3 is ignored
        idle(130);
        send(2'd0, 16'h4000);
        send(2'd1, 16'h8000);
        send(2'd3, 16'h1234);
        idle(10);
        chk("ch3_no_sta", 32'(sta_seen), 32'd2);
        push(32'h3F000000, 32'hBF800000, 32'hBF000000);
        send(2'd2, 16'hC000);
        wait_sta("ch3", 10, cyc);
        chk("ch3_latency", 32'(cyc), 32'd2);

        // next-frame c lands on the commit edge
        idle(130);
        send(2'd0, 16'h2000);
        send(2'd1, 16'hC000);
        push(32'h3E800000, 32'hBF000000, 32'h3F7FFE00);
        send(2'd2, 16'h7FFF);
        send(2'd2, 16'h0001);
        wait_sta("simul", 10, cyc);
        chk("simul_latency", 32'(cyc), 32'd1);
        t0 = tick;
        send(2'd0, 16'h0001);
        push(32'h38000000, 32'hB8000000, 32'h38000000);
        send(2'd1, 16'hFFFF);
        wait_sta("simul_next", 200, cyc);
        chk("simul_gap", 32'(tick - t0), 32'd128);
        chk("simul_overrun", 32'(overrun), 32'd0);
        chk("simul_dup_err", 32'(dup_err), 32'd0);

        // duplicate channel in a collecting frame
        idle(130);
        exp_sta = sta_seen;
        send(2'd0, 16'h4000);
        send(2'd0, 16'hC000);
        send(2'd1, 16'h8000);
        push(32'hBF000000, 32'hBF800000, 32'h3E800000);
        send(2'd2, 16'h2000);
        wait_sta("dup", 10, cyc);
        chk("dup_latency", 32'(cyc), 32'd2);
        chk("dup_err_set", 32'(dup_err), 32'd1);
        chk("dup_no_overrun", 32'(overrun), 32'd0);
        idle(200);
        chk("dup_single_sta", 32'(sta_seen), 32'(exp_sta + 1));

        // back-to-back frames, resend while waiting on the gap
        send(2'd0, 16'h0001);
        send(2'd1, 16'h0001);
        push(32'h38000000, 32'h38000000, 32'h38000000);
        send(2'd2, 16'h0001);
        wait_sta("gap_first", 10, cyc);
        t0 = tick;
        send(2'd0, 16'h4000);
        send(2'd1, 16'h8000);
        send(2'd2, 16'h7FFF);
        push(32'hBF000000, 32'hBF800000, 32'h3F7FFE00);
        send(2'd0, 16'hC000);
        wait_sta("gap_second", 200, cyc);
        chk("gap_spacing", 32'(tick - t0), 32'd128);
        chk("gap_overrun", 32'(overrun), 32'd1);

        // async reset with mask=011 and c in flight
        idle(5);
        send(2'd0, 16'h4000);
        send(2'd1, 16'h8000);
        idle(2);
        adc_valid = 1'b1;
        adc_ch    = 2'd2;
        adc_data  = 16'h7FFF;
        step();
        adc_valid = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk_zero("rst_mid");
        exp_sta = sta_seen;
        idle(20);
        chk("rst_mid_no_sta", 32'(sta_seen), 32'(exp_sta));
        send(2'd0, 16'h4000);
        send(2'd1, 16'h8000);
        push(32'h3F000000, 32'hBF800000, 32'h00000000);
        send(2'd2, 16'h0000);
        wait_sta("rst_after", 10, cyc);
        chk("rst_after_latency", 32'(cyc), 32'd2);
        chk("rst_after_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("rst_after_dup_err", 32'(dup_err), 32'd0);

        // synchronous clear with mask=011 and c in flight
        send(2'd0, 16'h2000);
        send(2'd1, 16'hC000);
        idle(2);
        adc_valid = 1'b1;
        adc_ch    = 2'd2;
        adc_data  = 16'h0001;
        step();
        adc_valid = 1'b0;
        rst_user  = 1'b1;
        step();
        rst_user  = 1'b0;
        chk_zero("user_mid");
        exp_sta = sta_seen;
        idle(20);
        chk("user_mid_no_sta", 32'(sta_seen), 32'(exp_sta));
        send(2'd0, 16'h7FFF);
        send(2'd1, 16'h0001);
        push(32'h3F7FFE00, 32'h38000000, 32'hB8000000);
        send(2'd2, 16'hFFFF);
        wait_sta("user_after", 10, cyc);
        chk("user_after_latency", 32'(cyc), 32'd2);
        chk("user_after_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("user_after_dup_err", 32'(dup_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
